// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage load-use/branch interlock with stall FSM; HAZARD_STATS_EN adds stall/flush counters
module hazard_stall_unit #(
    parameter int REG_W = 5
`ifdef HAZARD_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_branch_taken,
    input  logic             idex_memread,
    input  logic             idex_regwrite,
    input  logic [REG_W-1:0] idex_writereg,
    input  logic             exmem_memread,
    input  logic [REG_W-1:0] exmem_writereg,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
`endif
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             stall_active
);
    typedef enum logic [1:0] {RUN, STALL2, STALL1} state_t;
    state_t state, next_state;
    logic match_ex, match_mem, h2, h1, run, stall;
    always_comb begin
        match_ex   = (idex_writereg != '0) && ((idex_writereg == id_rs) || (id_uses_rt && idex_writereg == id_rt));
        match_mem  = (exmem_writereg != '0) && ((exmem_writereg == id_rs) || (id_uses_rt && exmem_writereg == id_rt));
        h2         = id_is_branch && idex_memread && match_ex;
        h1         = (!id_is_branch && idex_memread && match_ex)
                   || (id_is_branch && idex_regwrite && !idex_memread && match_ex)
                   || (id_is_branch && exmem_memread && match_mem);
        run        = state == RUN;
        // outside RUN the stall is unconditional, so no input reaches the outputs there
        stall      = !reset && (!run || h2 || h1);
        pc_write     = !stall;
        ifid_write   = !stall;
        idex_bubble  = stall;
        ifid_flush   = !reset && run && !stall && id_is_branch && id_branch_taken;
        stall_active = !reset && !run;
        next_state   = (run && h2) ? STALL1 : RUN;
    end
    always_ff @(posedge clk)
        state <= reset ? RUN : next_state;
`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        stall_cycles <= reset ? '0 : (idex_bubble && !(&stall_cycles)) ? stall_cycles + 1'b1 : stall_cycles;
        flush_count  <= reset ? '0 : (ifid_flush && !(&flush_count)) ? flush_count + 1'b1 : flush_count;
    end
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed and random checks of hazard_stall_unit against a stall-countdown model
module tb_hazard_stall_unit;
    logic clk = 1'b0;
    logic reset;
    logic [4:0] id_rs, id_rt, idex_writereg, exmem_writereg;
    logic id_uses_rt, id_is_branch, id_branch_taken, idex_memread, idex_regwrite, exmem_memread;
    logic pc_write, ifid_write, idex_bubble, ifid_flush, stall_active;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles, flush_count;
    int m_stall = 0, m_flush = 0;
`endif
    int n_vec = 0, n_err = 0, rem = 0;

    hazard_stall_unit dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
        .idex_memread(idex_memread), .idex_regwrite(idex_regwrite), .idex_writereg(idex_writereg),
        .exmem_memread(exmem_memread), .exmem_writereg(exmem_writereg),
`ifdef HAZARD_STATS_EN
        .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .stall_active(stall_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // number of stall cycles the ID instruction needs, straight from the hazard classes
    function automatic int need();
        bit mex, mmem;
        mex  = idex_writereg != 0 && (idex_writereg == id_rs || (id_uses_rt && idex_writereg == id_rt));
        mmem = exmem_writereg != 0 && (exmem_writereg == id_rs || (id_uses_rt && exmem_writereg == id_rt));
        if (id_is_branch && idex_memread && mex) return 2;
        if (idex_memread && mex) return 1;
        if (id_is_branch && idex_regwrite && mex) return 1;
        if (id_is_branch && exmem_memread && mmem) return 1;
        return 0;
    endfunction

    task automatic drv(input int rs, input int rt, input bit ur, input bit br, input bit tk,
                       input bit mr, input bit rw, input int wr, input bit emr, input int ewr);
        id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = ur; id_is_branch = br; id_branch_taken = tk;
        idex_memread = mr; idex_regwrite = rw; idex_writereg = 5'(wr);
        exmem_memread = emr; exmem_writereg = 5'(ewr);
    endtask

    task automatic step();
        int n;
        bit st, fl, act;
        #1;
        n = 0;
        if (reset) begin
            st = 0; fl = 0; act = 0;
        end else if (rem > 0) begin
            st = 1; fl = 0; act = 1;
        end else begin
            n = need();
            st = n > 0; act = 0;
            fl = !st && id_is_branch && id_branch_taken;
        end
        chk("pc_write", 32'(pc_write), 32'(!st));
        chk("ifid_write", 32'(ifid_write), 32'(!st));
        chk("idex_bubble", 32'(idex_bubble), 32'(st));
        chk("ifid_flush", 32'(ifid_flush), 32'(fl));
        chk("stall_active", 32'(stall_active), 32'(act));
`ifdef HAZARD_STATS_EN
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        chk("flush_count", 32'(flush_count), 32'(m_flush));
`endif
        @(posedge clk);
        if (reset) begin
            rem = 0;
`ifdef HAZARD_STATS_EN
            m_stall = 0; m_flush = 0;
`endif
        end else begin
            rem = rem > 0 ? rem - 1 : (n > 0 ? n - 1 : 0);
`ifdef HAZARD_STATS_EN
            if (st && m_stall < 65535) m_stall++;
            if (fl && m_flush < 65535) m_flush++;
`endif
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step(); step();
        reset = 1'b0;
        idle();
        drv(2, 5, 1, 0, 0, 1, 1, 2, 0, 0); step();
        idle();
        drv(1, 3, 1, 1, 0, 1, 1, 3, 0, 0); step();
        drv(1, 3, 1, 1, 1, 0, 0, 0, 0, 0); step();
        idle();
        drv(4, 7, 1, 1, 0, 0, 1, 4, 0, 0); step();
        drv(0, 7, 1, 1, 0, 0, 1, 0, 0, 0); step();
        drv(1, 2, 1, 1, 1, 0, 0, 0, 0, 0); step();
        drv(5, 6, 1, 1, 0, 0, 0, 0, 1, 6); step();
        drv(5, 6, 0, 0, 0, 1, 1, 6, 0, 0); step();
        drv(1, 3, 1, 1, 0, 1, 1, 3, 0, 0); step();
        reset = 1'b1; drv(1, 3, 1, 1, 0, 1, 1, 3, 0, 0); step();
        reset = 1'b0;
        drv(1, 2, 1, 1, 1, 0, 0, 0, 0, 0); step();
        idle();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 31) == 0);
            drv($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3));
            step();
        end
        reset = 1'b0;
`ifdef HAZARD_STATS_EN
        reset = 1'b1; idle(); reset = 1'b0;
        drv(1, 3, 1, 1, 0, 1, 1, 3, 0, 0); step();
        idle();
        drv(1, 2, 1, 1, 1, 0, 0, 0, 0, 0); step();
        chk("h2_then_flush_stalls", 32'(stall_cycles), 32'd2);
        chk("h2_then_flush_flushes", 32'(flush_count), 32'd1);
        drv(2, 0, 0, 0, 0, 1, 1, 2, 0, 0);
        for (int i = 0; i < 65540; i++) step();
        chk("stall_saturate", 32'(stall_cycles), 32'h0000ffff);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Interlock controller in the ID stage of the 5-stage MIPS pipeline; complements the bypass/forwarding logic by handling every hazard that forwarding cannot resolve.
- Detects load-use and branch-in-ID data hazards, then freezes PC and IF/ID and injects bubbles into ID/EX for the required number of cycles.
- Flushes IF/ID on a taken branch.
- Multi-cycle stalls are sequenced by an internal FSM, so the hazard is not re-evaluated while a stall is in progress.

Parameters:
- REG_W, 5, register-specifier width
- CNT_W, 16, width of statistics counters (used only with the optional feature)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_rs  in  REG_W  Rs field of instruction in ID
- id_rt  in  REG_W  Rt field of instruction in ID
- id_uses_rt  in  1  instruction in ID reads Rt as a source (R-type, sw, beq/bne)
- id_is_branch  in  1  instruction in ID is beq/bne (compared in ID)
- id_branch_taken  in  1  ID comparator result; valid only when id_is_branch=1
- idex_memread  in  1  instruction in EX is a load
- idex_regwrite  in  1  instruction in EX writes the register file
- idex_writereg  in  REG_W  destination register of instruction in EX
- exmem_memread  in  1  instruction in MEM is a load
- exmem_writereg  in  REG_W  destination register of instruction in MEM
- pc_write  out  1  1 = PC may update
- ifid_write  out  1  1 = IF/ID may load
- idex_bubble  out  1  1 = zero ID/EX control signals this cycle
- ifid_flush  out  1  1 = replace IF/ID contents with a nop
- stall_active  out  1  FSM is not in RUN (debug/visibility)

Behaviour:
- Match(x) = (x != 0) && ((x == id_rs) || (id_uses_rt && x == id_rt)). Register 0 never produces a hazard.
- Hazard classes, evaluated only in state RUN:
  - H2: id_is_branch && idex_memread && Match(idex_writereg). Two stall cycles.
  - H1a: !id_is_branch && idex_memread && Match(idex_writereg). Load-use; one stall cycle.
  - H1b: id_is_branch && idex_regwrite && !idex_memread && Match(idex_writereg). One stall cycle.
  - H1c: id_is_branch && exmem_memread && Match(exmem_writereg). One stall cycle.
  - Priority: H2 > H1a/H1b/H1c.
- FSM states: RUN, STALL2, STALL1.
  - RUN with H2: assert stall outputs this cycle (Mealy); next state STALL1. STALL2 is reserved for the H2 cycle encoding; the first stall cycle is spent in RUN.
  - RUN with any H1: assert stall outputs this cycle; next state RUN (the instruction is re-evaluated next cycle).
  - STALL1: stall outputs asserted unconditionally (Moore); next state RUN.
  - Net effect: an H2 hazard gives exactly 2 stall cycles; an H1 hazard gives 1.
- Stall outputs: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
- No hazard in RUN: pc_write=1, ifid_write=1, idex_bubble=0; ifid_flush = id_is_branch && id_branch_taken.
- id_branch_taken is ignored in any stall cycle. A flush is never asserted together with a stall.
- stall_active = 1 whenever the state is not RUN.
- Reset, taking effect on the next edge and also overriding outputs while reset=1:
  - state = RUN
  - pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, stall_active=0
- Reset mid-stall aborts the stall. The first cycle after reset is a fresh RUN evaluation.
- Zero latency from hazard inputs to outputs in RUN; no combinational path from inputs to outputs in STALL1.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, add two output ports:
  - stall_cycles (CNT_W): increments on every cycle with idex_bubble=1
  - flush_count (CNT_W): increments on every cycle with ifid_flush=1
- Both counters saturate at all-ones and clear to 0 on reset.
- When undefined, the ports and registers are absent and the remaining behaviour is identical.

Test Plan:
- lw $2 in EX (idex_memread=1, idex_writereg=2); add in ID with rs=2 -> exactly 1 cycle of pc_write=0, ifid_write=0, idex_bubble=1, then normal operation.
- lw $3 in EX; beq in ID with rt=3, id_uses_rt=1 -> 2 consecutive stall cycles, stall_active=1 in the second cycle only, then RUN.
- add $4 in EX (regwrite=1, memread=0); beq in ID with rs=4 -> 1 stall cycle. Same case with idex_writereg=0 -> no stall.
- beq in ID, no hazard, id_branch_taken=1 -> ifid_flush=1 for 1 cycle with pc_write=1. With id_branch_taken=1 during STALL1 -> ifid_flush=0.
- Enter STALL1, then assert reset for 1 cycle -> outputs return to 1,1,0,0; stall_active=0; no residual stall.
- With HAZARD_STATS_EN: run the H2 scenario, then a taken branch -> stall_cycles=2, flush_count=1. Force 65536 stall cycles -> stall_cycles holds at 0xFFFF.
